// File: rtl/call_stack_ctrl.sv
// call_stack_ctrl
// Sequences a 16-slot (15 usable) 8-bit hardware stack for CALL, RET, INT and RETI.
// Legality of every request is decided from the controller's own occupancy count at
// accept time, so the stack never sees an overflowing or underflowing strobe.
// All outputs are registered.
// Optional build macro: CALL_STACK_INT_NEST_EN enables up to three nested INT levels.
// When it is undefined, only one INT level is allowed.

module call_stack_ctrl #(
    parameter int          DEPTH      = 15,
    parameter logic [7:0]  INT_VECTOR = 8'hF0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [7:0]  req_pc,
    input  logic [7:0]  req_target,
    input  logic [3:0]  req_flags,
    output logic        req_ready,
    output logic        done,
    output logic [7:0]  done_pc,
    output logic [3:0]  done_flags,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic        stk_push,
    output logic        stk_pop,
    output logic [7:0]  stk_din,
    input  logic [7:0]  stk_dout,
    input  logic        stk_overflow,
    input  logic        stk_underflow,
    output logic        desync,
    output logic        int_active,
    output logic [4:0]  depth
);

    localparam logic [1:0] OP_CALL = 2'b00;
    localparam logic [1:0] OP_RET  = 2'b01;
    localparam logic [1:0] OP_INT  = 2'b10;
    localparam logic [1:0] OP_RETI = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PUSH_PC = 3'd1,
        PUSH_FL = 3'd2,
        POP_1   = 3'd3,
        POP_2   = 3'd4,
        DONE    = 3'd5,
        FAULT   = 3'd6
    } state_t;

    state_t      state_r;
    logic [1:0]  op_r;
    logic [7:0]  target_r;
    logic [3:0]  flags_r;
    logic [3:0]  flags_cap_r;
    logic        nest_full_s;
    logic [1:0]  req_code_s;
`ifdef CALL_STACK_INT_NEST_EN
    logic [1:0]  nest_cnt_r;
`endif

    // Returns 2'b00 for a legal request, otherwise the fault code to report.
    function automatic logic [1:0] legality(input logic [1:0] op,
                                            input logic [4:0] occ,
                                            input logic       nest_full);
        logic [1:0] code;
        code = 2'b00;
        case (op)
            OP_CALL: if (occ > 5'(DEPTH - 1)) code = 2'b01; else code = 2'b00;
            OP_INT: begin
                if (nest_full)                 code = 2'b11;
                else if (occ > 5'(DEPTH - 2))  code = 2'b01;
                else                           code = 2'b00;
            end
            OP_RET:  if (occ < 5'd1) code = 2'b10; else code = 2'b00;
            OP_RETI: if (occ < 5'd2) code = 2'b10; else code = 2'b00;
            default: code = 2'b00;
        endcase
        return code;
    endfunction

    // Decide whether another INT level may be opened and classify the pending request.
    always_comb begin
        nest_full_s = 1'b0;
`ifdef CALL_STACK_INT_NEST_EN
        nest_full_s = (nest_cnt_r == 2'd3);
`else
        nest_full_s = int_active;
`endif
        req_code_s = legality(req_op, depth, nest_full_s);
    end

    // Main sequencer: state, stack strobes, occupancy, results and sticky status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            op_r        <= 2'b00;
            target_r    <= 8'h00;
            flags_r     <= 4'h0;
            flags_cap_r <= 4'h0;
            req_ready   <= 1'b1;
            done        <= 1'b0;
            done_pc     <= 8'h00;
            done_flags  <= 4'h0;
            fault       <= 1'b0;
            fault_code  <= 2'b00;
            stk_push    <= 1'b0;
            stk_pop     <= 1'b0;
            stk_din     <= 8'h00;
            desync      <= 1'b0;
            int_active  <= 1'b0;
            depth       <= 5'd0;
`ifdef CALL_STACK_INT_NEST_EN
            nest_cnt_r  <= 2'd0;
`endif
        end else begin
            done   <= 1'b0;
            fault  <= 1'b0;
            desync <= desync | stk_overflow | stk_underflow;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        op_r      <= req_op;
                        target_r  <= req_target;
                        flags_r   <= req_flags;
                        req_ready <= 1'b0;
                        if (req_code_s != 2'b00) begin
                            state_r    <= FAULT;
                            fault      <= 1'b1;
                            fault_code <= req_code_s;
                        end else if ((req_op == OP_CALL) || (req_op == OP_INT)) begin
                            state_r  <= PUSH_PC;
                            stk_push <= 1'b1;
                            stk_din  <= req_pc;
                        end else begin
                            state_r <= POP_1;
                            stk_pop <= 1'b1;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                PUSH_PC: begin
                    depth <= depth + 5'd1;
                    if (op_r == OP_INT) begin
                        state_r  <= PUSH_FL;
                        stk_push <= 1'b1;
                        stk_din  <= {4'b0000, flags_r};
                    end else begin
                        state_r    <= DONE;
                        stk_push   <= 1'b0;
                        stk_din    <= 8'h00;
                        done       <= 1'b1;
                        done_pc    <= target_r;
                        done_flags <= 4'h0;
                    end
                end
                PUSH_FL: begin
                    depth      <= depth + 5'd1;
                    state_r    <= DONE;
                    stk_push   <= 1'b0;
                    stk_din    <= 8'h00;
                    done       <= 1'b1;
                    done_pc    <= INT_VECTOR;
                    done_flags <= 4'h0;
                    int_active <= 1'b1;
`ifdef CALL_STACK_INT_NEST_EN
                    nest_cnt_r <= nest_cnt_r + 2'd1;
`endif
                end
                POP_1: begin
                    depth <= depth - 5'd1;
                    if (op_r == OP_RETI) begin
                        state_r     <= POP_2;
                        flags_cap_r <= stk_dout[3:0];
                    end else begin
                        state_r    <= DONE;
                        stk_pop    <= 1'b0;
                        done       <= 1'b1;
                        done_pc    <= stk_dout;
                        done_flags <= 4'h0;
                    end
                end
                POP_2: begin
                    depth      <= depth - 5'd1;
                    state_r    <= DONE;
                    stk_pop    <= 1'b0;
                    done       <= 1'b1;
                    done_pc    <= stk_dout;
                    done_flags <= flags_cap_r;
`ifdef CALL_STACK_INT_NEST_EN
                    if (nest_cnt_r != 2'd0) begin
                        nest_cnt_r <= nest_cnt_r - 2'd1;
                        int_active <= (nest_cnt_r > 2'd1);
                    end else begin
                        int_active <= 1'b0;
                    end
`else
                    int_active <= 1'b0;
`endif
                end
                DONE: begin
                    state_r   <= IDLE;
                    req_ready <= 1'b1;
                end
                FAULT: begin
                    state_r    <= IDLE;
                    fault_code <= 2'b00;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state_r   <= IDLE;
                    stk_push  <= 1'b0;
                    stk_pop   <= 1'b0;
                    stk_din   <= 8'h00;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Scoreboard bench for call_stack_ctrl with a behavioural 16-slot stack model.
module tb_call_stack_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [7:0]  req_pc;
    logic [7:0]  req_target;
    logic [3:0]  req_flags;
    logic        req_ready;
    logic        done;
    logic [7:0]  done_pc;
    logic [3:0]  done_flags;
    logic        fault;
    logic [1:0]  fault_code;
    logic        stk_push;
    logic        stk_pop;
    logic [7:0]  stk_din;
    logic [7:0]  stk_dout;
    logic        stk_overflow;
    logic        stk_underflow;
    logic        desync;
    logic        int_active;
    logic [4:0]  depth;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic       is_fault;
        logic [7:0] pc;
        logic [3:0] flags;
        logic [1:0] code;
        int         cyc;
    } exp_t;
    exp_t q[$];

    // Stack model
    logic [7:0] mem [16];
    int         cnt;

    call_stack_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_op(req_op), .req_pc(req_pc),
        .req_target(req_target), .req_flags(req_flags), .req_ready(req_ready),
        .done(done), .done_pc(done_pc), .done_flags(done_flags),
        .fault(fault), .fault_code(fault_code),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
        .stk_dout(stk_dout), .stk_overflow(stk_overflow), .stk_underflow(stk_underflow),
        .desync(desync), .int_active(int_active), .depth(depth)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt           <= 0;
            stk_overflow  <= 1'b0;
            stk_underflow <= 1'b0;
        end else begin
            if (stk_push) begin
                if (cnt >= 15) stk_overflow <= 1'b1;
                else begin
                    mem[cnt] <= stk_din;
                    cnt      <= cnt + 1;
                end
            end else if (stk_pop) begin
                if (cnt == 0) stk_underflow <= 1'b1;
                else cnt <= cnt - 1;
            end
        end
    end

    always_comb begin
        stk_dout = 8'h00;
        if (cnt > 0) stk_dout = mem[cnt - 1];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: protocol checks every cycle, scoreboard compare on done/fault.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("push_pop_excl", {31'd0, stk_push & stk_pop}, 32'd0);
            if (!stk_push) chk("din_zero_idle", {24'd0, stk_din}, 32'd0);
            if (done || fault) begin
                chk("done_fault_excl", {31'd0, done & fault}, 32'd0);
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output done=%0b fault=%0b pc=%0h", done, fault, done_pc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("kind_is_fault", {31'd0, fault}, {31'd0, e.is_fault});
                    chk("latency_cycle", cyc, e.cyc);
                    if (e.is_fault) begin
                        chk("fault_code", {30'd0, fault_code}, {30'd0, e.code});
                    end else begin
                        chk("done_pc", {24'd0, done_pc}, {24'd0, e.pc});
                        chk("done_flags", {28'd0, done_flags}, {28'd0, e.flags});
                    end
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] pc, input logic [7:0] tgt,
                         input logic [3:0] fl, input logic efault, input logic [7:0] epc,
                         input logic [3:0] efl, input logic [1:0] ecode, input int lat);
        exp_t e;
        @(negedge clk);
        for (int n = 0; n < 50; n++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        chk("ready_before_issue", {31'd0, req_ready}, 32'd1);
        req_op     = op;
        req_pc     = pc;
        req_target = tgt;
        req_flags  = fl;
        req_valid  = 1'b1;
        e.is_fault = efault;
        e.pc       = epc;
        e.flags    = efl;
        e.code     = ecode;
        e.cyc      = cyc + lat;
        q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (q.size() == 0 && req_ready) break;
        end
        chk("idle_reached", {31'd0, (q.size() == 0 && req_ready)}, 32'd1);
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_pc     = 8'h00;
        req_target = 8'h00;
        req_flags  = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_depth", {27'd0, depth}, 32'd0);
        chk("rst_push", {31'd0, stk_push}, 32'd0);
        chk("rst_done_pc", {24'd0, done_pc}, 32'd0);
        reset_n = 1'b1;

        // CALL then RET
        issue(2'b00, 8'h12, 8'h40, 4'h0, 1'b0, 8'h40, 4'h0, 2'b00, 2);
        wait_idle();
        chk("call_depth", {27'd0, depth}, 32'd1);
        chk("call_stack_top", {24'd0, stk_dout}, 32'h12);
        issue(2'b01, 8'h00, 8'h00, 4'h0, 1'b0, 8'h12, 4'h0, 2'b00, 2);
        wait_idle();
        chk("ret_depth", {27'd0, depth}, 32'd0);
        chk("ret_no_flags", {30'd0, stk_overflow, stk_underflow}, 32'd0);

        // INT
        issue(2'b10, 8'h33, 8'h00, 4'hA, 1'b0, 8'hF0, 4'h0, 2'b00, 3);
        wait_idle();
        chk("int_active_set", {31'd0, int_active}, 32'd1);
        chk("int_depth", {27'd0, depth}, 32'd2);
        chk("int_push0", {24'd0, mem[0]}, 32'h33);
        chk("int_push1", {24'd0, mem[1]}, 32'h0A);

        // Second INT while active
`ifdef CALL_STACK_INT_NEST_EN
        issue(2'b10, 8'h55, 8'h00, 4'h5, 1'b0, 8'hF0, 4'h0, 2'b00, 3);
        wait_idle();
        chk("nest_depth", {27'd0, depth}, 32'd4);
        issue(2'b11, 8'h00, 8'h00, 4'h0, 1'b0, 8'h55, 4'h5, 2'b00, 3);
        wait_idle();
        chk("nest_still_active", {31'd0, int_active}, 32'd1);
`else
        issue(2'b10, 8'h55, 8'h00, 4'h5, 1'b1, 8'h00, 4'h0, 2'b11, 1);
        wait_idle();
        chk("nested_int_no_push", {27'd0, depth}, 32'd2);
`endif

        // RETI
        issue(2'b11, 8'h00, 8'h00, 4'h0, 1'b0, 8'h33, 4'hA, 2'b00, 3);
        wait_idle();
        chk("reti_int_clear", {31'd0, int_active}, 32'd0);
        chk("reti_depth", {27'd0, depth}, 32'd0);

        // Underflow refusals
        issue(2'b01, 8'h00, 8'h00, 4'h0, 1'b1, 8'h00, 4'h0, 2'b10, 1);
        wait_idle();
        issue(2'b11, 8'h00, 8'h00, 4'h0, 1'b1, 8'h00, 4'h0, 2'b10, 1);
        wait_idle();
        chk("underflow_depth", {27'd0, depth}, 32'd0);

        // Fill to 15, then overflow refusal
        for (int i = 1; i <= 15; i++) begin
            issue(2'b00, 8'(i), 8'(8'h80 + i), 4'h0, 1'b0, 8'(8'h80 + i), 4'h0, 2'b00, 2);
            wait_idle();
        end
        chk("full_depth", {27'd0, depth}, 32'd15);
        issue(2'b00, 8'h99, 8'hAA, 4'h0, 1'b1, 8'h00, 4'h0, 2'b01, 1);
        wait_idle();
        chk("ovf_depth", {27'd0, depth}, 32'd15);
        chk("ovf_model_cnt", cnt, 32'd15);
        chk("ovf_desync", {31'd0, desync}, 32'd0);

        // INT at depth 14
        issue(2'b01, 8'h00, 8'h00, 4'h0, 1'b0, 8'h0F, 4'h0, 2'b00, 2);
        wait_idle();
        issue(2'b10, 8'h77, 8'h00, 4'h3, 1'b1, 8'h00, 4'h0, 2'b01, 1);
        wait_idle();
        chk("int14_depth", {27'd0, depth}, 32'd14);

        // Clean restart, then reset during PUSH_FL of an INT
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        issue(2'b10, 8'h21, 8'h00, 4'h6, 1'b0, 8'hF0, 4'h0, 2'b00, 3);
        @(posedge clk);
        #1;
        chk("push_fl_din", {24'd0, stk_din}, 32'h06);
        chk("push_fl_push", {31'd0, stk_push}, 32'd1);
        reset_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_push", {31'd0, stk_push}, 32'd0);
        chk("midrst_din", {24'd0, stk_din}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_depth", {27'd0, depth}, 32'd0);
        chk("midrst_int", {31'd0, int_active}, 32'd0);
        chk("midrst_done_pc", {24'd0, done_pc}, 32'd0);
        repeat (2) @(negedge clk);
        chk("midrst_quiet", {30'd0, stk_push, done}, 32'd0);
        reset_n = 1'b1;

        // Normal operation after reset
        issue(2'b00, 8'h01, 8'h02, 4'h0, 1'b0, 8'h02, 4'h0, 2'b00, 2);
        wait_idle();
        chk("final_depth", {27'd0, depth}, 32'd1);
        chk("final_desync", {31'd0, desync}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached");
        $fatal(1);
    end

endmodule
